// File: rtl/mips_fetch_sequencer.sv
// Multicycle fetch/execute sequencer feeding the MIPS decoder.
// Owns the state register, instruction register and program counter, and
// defers taken branch/jump targets past their delay-slot instruction.
module mips_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        halt,
  input  logic        extra,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [1:0]  state,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        active
);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec1 = 2'b01,
    StExec2 = 2'b10,
    StHalt  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] delay_target_q, delay_target_d;
  logic        delay_pending_q, delay_pending_d;
  logic        active_q, active_d;
  logic        leave_to_fetch;
  logic        capture;

  // Next-state, PC-update and branch-capture logic.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    delay_target_d  = delay_target_q;
    delay_pending_d = delay_pending_q;
    active_d        = active_q;
    leave_to_fetch  = 1'b0;
    capture         = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (halt) begin
          state_d  = StHalt;
          active_d = 1'b0;
        end else if (!waitrequest) begin
          instr_d = readdata;
          state_d = StExec1;
        end
      end
      StExec1: begin
        if (!waitrequest) begin
          // A branch seen while one is already pending sits in a delay slot
          // and is dropped.
          capture = branch_taken && !delay_pending_q;
          if (extra) begin
            state_d = StExec2;
          end else begin
            state_d        = StFetch;
            leave_to_fetch = 1'b1;
          end
        end
      end
      StExec2: begin
        state_d        = StFetch;
        leave_to_fetch = 1'b1;
      end
      StHalt: begin
      end
    endcase

    if (leave_to_fetch) begin
      if (delay_pending_q) begin
        pc_d            = delay_target_q;
        delay_pending_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end

    // Capture only fires with no pending target, so it never collides with
    // the commit above.
    if (capture) begin
      delay_pending_d = 1'b1;
      delay_target_d  = branch_target;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StFetch;
      pc_q            <= RESET_VECTOR;
      instr_q         <= 32'h0;
      delay_target_q  <= 32'h0;
      delay_pending_q <= 1'b0;
      active_q        <= 1'b1;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      delay_target_q  <= delay_target_d;
      delay_pending_q <= delay_pending_d;
      active_q        <= active_d;
    end
  end

  assign state       = state_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign active      = active_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Self-checking bench for mips_fetch_sequencer: directed scenarios plus
// randomized instruction streams checked against an instruction-level model.
module tb_mips_fetch_sequencer;

  localparam logic [31:0] Rv = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        halt;
  logic        extra;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [1:0]  state;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        active;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural PC, latched instruction, deferred target.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_pend;
  logic [31:0] m_tgt;

  mips_fetch_sequencer #(.RESET_VECTOR(Rv)) dut (
    .clk          (clk),
    .reset        (reset),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .halt         (halt),
    .extra        (extra),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .state        (state),
    .instruction  (instruction),
    .pc           (pc),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc    = Rv;
    m_instr = 32'h0;
    m_pend  = 1'b0;
    m_tgt   = 32'h0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    waitrequest  = 1'($urandom);
    readdata     = $urandom;
    halt         = 1'($urandom);
    extra        = 1'($urandom);
    branch_taken = 1'($urandom);
    tick();
    reset = 1'b0;
    halt  = 1'b0;
    model_reset();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_pc", pc, Rv);
    check_eq("rst_instr", instruction, 32'h0);
    check_eq("rst_active", 32'(active), 32'd1);
  endtask

  // Commit point of an instruction: take the deferred target, else step by 4.
  task automatic model_advance();
    if (m_pend) begin
      m_pc   = m_tgt;
      m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_frozen(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      waitrequest  = 1'($urandom);
      readdata     = $urandom;
      halt         = 1'($urandom);
      extra        = 1'($urandom);
      branch_taken = 1'($urandom);
      tick();
      check_eq("halt_state", 32'(state), 32'd3);
      check_eq("halt_instr", instruction, m_instr);
      check_eq("halt_pc", pc, m_pc);
      check_eq("halt_active", 32'(active), 32'd0);
    end
    halt = 1'b0;
  endtask

  // One whole instruction: fs fetch stalls, es EXEC1 stalls, optional EXEC2.
  task automatic run_instr(input int fs, input int es, input bit ex, input bit tk,
                           input logic [31:0] tgt, input logic [31:0] data,
                           output bit halted);
    bit new_br;
    halted = 1'b0;
    if (m_pc == 32'h0) begin
      waitrequest  = 1'($urandom);
      readdata     = data;
      halt         = 1'b1;
      branch_taken = 1'($urandom);
      tick();
      halt = 1'b0;
      check_eq("enter_halt_state", 32'(state), 32'd3);
      check_eq("enter_halt_active", 32'(active), 32'd0);
      check_eq("enter_halt_instr", instruction, m_instr);
      check_eq("enter_halt_pc", pc, 32'h0);
      halted = 1'b1;
      return;
    end
    halt = 1'b0;
    for (int i = 0; i < fs; i++) begin
      waitrequest  = 1'b1;
      readdata     = $urandom;
      extra        = 1'($urandom);
      branch_taken = 1'($urandom);
      tick();
      check_eq("fstall_state", 32'(state), 32'd0);
      check_eq("fstall_pc", pc, m_pc);
      check_eq("fstall_instr", instruction, m_instr);
    end
    waitrequest  = 1'b0;
    readdata     = data;
    branch_taken = 1'($urandom);
    tick();
    m_instr = data;
    check_eq("exec1_state", 32'(state), 32'd1);
    check_eq("exec1_instr", instruction, m_instr);
    check_eq("exec1_pc", pc, m_pc);
    extra         = ex;
    branch_taken  = tk;
    branch_target = tgt;
    for (int i = 0; i < es; i++) begin
      waitrequest = 1'b1;
      readdata    = $urandom;
      tick();
      check_eq("estall_state", 32'(state), 32'd1);
      check_eq("estall_pc", pc, m_pc);
      check_eq("estall_instr", instruction, m_instr);
    end
    waitrequest = 1'b0;
    readdata    = $urandom;
    tick();
    new_br = tk && !m_pend;
    if (ex) begin
      check_eq("exec2_state", 32'(state), 32'd2);
      check_eq("exec2_pc", pc, m_pc);
      if (new_br) begin
        m_pend = 1'b1;
        m_tgt  = tgt;
      end
      waitrequest   = 1'($urandom);
      branch_taken  = 1'($urandom);
      branch_target = $urandom;
      tick();
      model_advance();
    end else begin
      model_advance();
      if (new_br) begin
        m_pend = 1'b1;
        m_tgt  = tgt;
      end
    end
    check_eq("next_state", 32'(state), 32'd0);
    check_eq("next_pc", pc, m_pc);
    check_eq("next_instr", instruction, m_instr);
    check_eq("next_active", 32'(active), 32'd1);
  endtask

  initial begin
    bit h;
    reset         = 1'b1;
    waitrequest   = 1'b0;
    readdata      = 32'h0;
    halt          = 1'b0;
    extra         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    do_reset();

    // Straight-line, fetch stall, load with EXEC1 stalls.
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h24020005, h);
    check_eq("addiu_pc", pc, 32'hBFC00004);
    run_instr(3, 0, 1'b0, 1'b0, 32'h0, 32'h00000000, h);
    run_instr(0, 2, 1'b1, 1'b0, 32'h0, 32'h8C430000, h);
    check_eq("load_pc", pc, 32'hBFC0000C);
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h00000000, h);

    // Branch at 0xBFC00010, second branch in its delay slot is dropped.
    run_instr(0, 0, 1'b0, 1'b1, 32'hBFC00100, 32'h10000003, h);
    check_eq("delay_slot_pc", pc, 32'hBFC00014);
    run_instr(0, 0, 1'b0, 1'b1, 32'h00000040, 32'h10000004, h);
    check_eq("branch_target_pc", pc, 32'hBFC00100);
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h00000000, h);
    check_eq("after_target_pc", pc, 32'hBFC00104);

    // JR to 0 halts after its delay slot.
    run_instr(0, 0, 1'b0, 1'b1, 32'h0, 32'h00000008, h);
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h00000000, h);
    check_eq("jr0_pc", pc, 32'h0);
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, h);
    check_eq("jr0_halted", 32'(h), 32'd1);
    check_frozen(4);
    do_reset();

    // Reset during EXEC2 with a pending target.
    run_instr(0, 0, 1'b0, 1'b1, 32'h00001000, 32'h10000010, h);
    waitrequest = 1'b0;
    readdata    = 32'h8C440004;
    tick();
    check_eq("pre_rst_exec1", 32'(state), 32'd1);
    extra        = 1'b1;
    branch_taken = 1'b0;
    tick();
    check_eq("pre_rst_exec2", 32'(state), 32'd2);
    extra = 1'b0;
    do_reset();
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h00000000, h);
    check_eq("post_rst_pc", pc, Rv + 32'd4);

    // PC wrap: 0xFFFFFFFC + 4 reaches 0 and halts.
    run_instr(0, 0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h08000000, h);
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h00000000, h);
    check_eq("wrap_pre_pc", pc, 32'hFFFFFFFC);
    run_instr(0, 0, 1'b0, 1'b0, 32'h0, 32'h00000000, h);
    check_eq("wrap_pc", pc, 32'h0);
    run_instr(1, 0, 1'b0, 1'b0, 32'h0, 32'h12345678, h);
    check_eq("wrap_halted", 32'(h), 32'd1);
    check_frozen(2);
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      int          fs;
      int          es;
      bit          ex;
      bit          tk;
      logic [31:0] tgt;
      fs  = $urandom_range(0, 3);
      es  = $urandom_range(0, 3);
      ex  = ($urandom_range(0, 3) == 0);
      tk  = !ex && ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 15) == 0) ? 32'h0 : {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      run_instr(fs, es, ex, tk, tgt, $urandom, h);
      if (h) begin
        check_frozen(2);
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fetch_sequencer.md
# mips_fetch_sequencer

Multicycle control sequencer and instruction/PC holding stage that sits directly upstream of the MIPS decoder. It runs the FETCH/EXEC1/EXEC2/HALT state machine and drives the decoder's `state`, `instruction` and `pc` inputs. It consumes the decoder's `Halt`, `Extra` and `is_branch` results. It also owns the program counter, including branch-delay-slot deferral of taken branch/jump targets.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- waitrequest  input  1  memory busy; stalls the current state.
- readdata  input  32  memory read data; instruction word during FETCH.
- halt  input  1  decoder `Halt` (pc == 0).
- extra  input  1  decoder `Extra`; current instruction needs EXEC2.
- branch_taken  input  1  decoder `is_branch`; sampled only on EXEC1 exit.
- branch_target  input  32  target address, valid with branch_taken.
- state  output  2  00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT.
- instruction  output  32  instruction register.
- pc  output  32  address of current instruction.
- active  output  1  high until HALT is entered.

## Operation
- All outputs are registered.
- Reset values: state=FETCH, pc=RESET_VECTOR, instruction=0, active=1, internal delay_pending=0, delay_target=0.
- FETCH:
  - halt=1 has priority: go to HALT, instruction unchanged, active<=0 on the same edge.
  - Else waitrequest=1: hold everything.
  - Else latch readdata into instruction and go to EXEC1.
- EXEC1:
  - waitrequest=1: hold everything, including the PC and delay registers.
  - Else extra=1: go to EXEC2. PC is not updated yet. Branch_taken is still sampled here (captured into delay registers).
  - Else extra=0: go to FETCH and apply the PC-update rule.
- EXEC2: unconditionally go to FETCH next cycle and apply the PC-update rule. waitrequest and branch_taken are ignored.
- HALT: absorbing. Only reset leaves it. instruction and pc are frozen.
- PC-update rule, evaluated when leaving toward FETCH:
  - delay_pending=1: pc<=delay_target, delay_pending<=0. This commits the previous branch after its delay slot.
  - Else pc<=pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Branch capture, on EXEC1 exit with waitrequest=0:
  - branch_taken=1 and delay_pending=0: delay_pending<=1, delay_target<=branch_target.
  - branch_taken=1 while delay_pending=1 (branch in a delay slot): the new branch is discarded; the existing pending target is applied.
- Reset mid-operation overrides everything, including a stalled memory access, HALT, and a pending delay target.

## Timing
- Unstalled 2-cycle instruction: FETCH, then EXEC1, then FETCH. Three-cycle (load) instruction: FETCH, EXEC1, EXEC2, FETCH.
- Each cycle of waitrequest=1 in FETCH or EXEC1 adds exactly one cycle.
- instruction is valid from the first EXEC1 cycle. It is stable until the next successful FETCH.
- pc changes only on the edge leaving EXEC1 (extra=0) or EXEC2.
- A taken branch redirects the FETCH after its delay-slot instruction: delay-slot pc = branch pc+4, then the target.
- active falls on the edge entering HALT and stays low until reset.
- Jumping to address 0: the target is committed, the next FETCH sees halt=1, then HALT is entered.

## Test plan
- Reset with waitrequest=0, readdata=32'h24020005 (ADDIU), extra=0 -> state 00→01→00; pc 0xBFC00000→0xBFC00004; instruction=32'h24020005 during EXEC1.
- FETCH with waitrequest=1 for 3 cycles -> state stays 00, pc unchanged. EXEC1 on the 4th edge after waitrequest falls.
- Load: extra=1, waitrequest=1 for 2 EXEC1 cycles -> sequence 00,01,01,01,10,00; pc advances by 4 only on the EXEC2 exit.
- Branch at pc=0xBFC00010, branch_taken=1, target 0xBFC00100 -> next pc 0xBFC00014 (delay slot), then 0xBFC00100.
- Branch in delay slot: second branch_taken=1 with target 0x00000040 -> pc goes to the first target, and 0x40 never appears. JR to 0x0 (after delay slot) -> pc=0, halt=1 in FETCH, state=11, active=0; later readdata changes leave instruction frozen.
- Assert reset during EXEC2, with delay_pending=1 -> next cycle state=00, pc=0xBFC00000, active=1, pending cleared (next PC update is +4).
